sici_pcs_rx_gearbox: RTL and testbench
======================================

// Module: sici_pcs_rx_gearbox
// PURPOSE
//  Rx gearbox directly upstream of the PCS frame synchroniser. Packs narrow IW-bit deserialiser
//  words into FW-bit PCS frames (Rx_Phy_Dat) with a one-cycle valid strobe (drives Rx_CE).
//  Executes the synchroniser's bit-slip request by discarding exactly one incoming bit,
//  shifting frame alignment by one bit per request.
// PARAMETERS
//  FW  40  PCS frame width (data + SH), output width; must match PCS FW
//  IW   8  deserialiser word width; 1 <= IW <= FW, FW need not be a multiple of IW
// PORTS
//  Ck       in   1   clock (single clock domain)
//  Rs       in   1   reset, asynchronous, active-low
//  CE       in   1   clock enable, active-high; all state holds when 0
//  In_Dat   in   IW  deserialiser word; MSB is the earliest-received bit
//  In_Vld   in   1   In_Dat valid, qualified by CE
//  Bit_Slp  in   1   slip request from frame synchroniser, active-high, sampled when CE=1
//  Out_Dat  out  FW  assembled frame; MSB is the earliest-received bit
//  Out_Vld  out  1   one-cycle strobe, Out_Dat valid
//  Slp_Ack  out  1   one-cycle pulse, a bit has been dropped
// BEHAVIOUR
//  - Reset (Rs=0, async): Out_Dat=0, Out_Vld=0, Slp_Ack=0, bit buffer and count cleared, slip
//    pending cleared. All stale bits are lost; there is no partial-frame carry over reset.
//  - Buffer: holds up to FW+IW-1 bits; count Cnt in 0..FW-1 between frames. Counter width is
//    clog2(FW+IW).
//  - Accept: on CE=1 & In_Vld=1, append the word's bits (MSB first) behind the buffered bits.
//    Bits appended = IW, or IW-1 if a slip applies to this word.
//  - Emit: if Cnt + appended >= FW, the oldest FW bits go to Out_Dat with Out_Vld=1 on the
//    next clock, and Cnt becomes Cnt + appended - FW. Remainder bits are retained in order.
//    Latency is 1 clock from the accepting edge. Out_Dat holds its value between strobes.
//  - Out_Vld and Slp_Ack are forced 0 on any cycle where no accept occurs. They are updated only
//    when CE=1; with CE=0 every register, including strobes, holds.
//  - Slip state machine: IDLE/PEND.
//    - IDLE + Bit_Slp=1 + accept in the same cycle: drop that word's MSB; stay IDLE; Slp_Ack=1
//      next clock.
//    - IDLE + Bit_Slp=1 with no accept: go to PEND.
//    - PEND + accept: drop the word's MSB; go to IDLE; Slp_Ack=1 next clock.
//    - PEND + Bit_Slp=1: ignored; at most one drop per pending request. Requests are not queued.
//  - Drops never cause a frame to be emitted early or twice; at most one frame is emitted per
//    accept (guaranteed since IW <= FW).
//  - No overflow or underflow is possible; with In_Vld=0 the buffer is static.
// TESTING (FW=40, IW=8)
//  1. Reset: hold Rs=0 with random inputs -> Out_Dat=40'h0, Out_Vld=0, Slp_Ack=0 throughout.
//  2. Words 8'h01,02,03,04,05 on consecutive cycles -> exactly one Out_Vld, 1 clk after the
//     5th word, with Out_Dat=40'h0102030405.
//  3. Same words with In_Vld alternating 1/0 and CE low for 3 cycles mid-stream -> identical
//     Out_Dat. Out_Vld comes 1 clk after the 5th accepted word. No change while CE=0.
//  4. Bit_Slp=1 with 1st word 8'h81, then 8'h02,03,04,05,80 -> Slp_Ack pulses 1 clk after
//     the 1st word. Out_Vld 1 clk after the 6th word, with Out_Dat=40'h020406080B. A following
//     8'h00 word leaves Cnt=15 with no emit.
//  5. Bit_Slp held for 4 cycles with In_Vld=0, then words -> exactly one bit dropped and one
//     Slp_Ack pulse.
//  6. Rs=0 pulse after 3 accepted words, then 8'h01..05 -> single frame 40'h0102030405 with
//     no stale bits.

Source files
------------

// File: rtl/sici_pcs_rx_gearbox.sv
// Rx gearbox: packs IW-bit deserialiser words into FW-bit PCS frames and
// drops one incoming bit per slip request from the frame synchroniser.
//
// state | meaning
// IDLE  | no slip outstanding; a request with an accepted word drops its MSB at once
// PEND  | slip requested with no word present; the next accepted word loses its MSB
module sici_pcs_rx_gearbox #(
    parameter int FW = 40,
    parameter int IW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ce,
    input  logic [IW-1:0] i_in_dat,
    input  logic          i_in_vld,
    input  logic          i_bit_slp,
    output logic [FW-1:0] o_out_dat,
    output logic          o_out_vld,
    output logic          o_slp_ack
);

    localparam int BW = FW + IW - 1;
    localparam int CW = $clog2(FW + IW);
    localparam int RW = (FW > 1) ? FW - 1 : 1;

    typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} slip_state_t;

    slip_state_t   r_state;
    logic [RW-1:0] r_buf;      // retained bits, right-aligned, oldest at bit r_cnt-1
    logic [CW-1:0] r_cnt;
    logic [FW-1:0] r_out_dat;
    logic          r_out_vld;
    logic          r_slp_ack;

    logic          w_acc;
    logic          w_slip;
    logic [IW-1:0] w_word;
    logic [CW-1:0] w_n;
    logic [CW-1:0] w_total;
    logic          w_emit;
    logic [CW-1:0] w_rem;
    logic [BW-1:0] w_ext;
    logic [FW-1:0] w_frame;
    logic [RW-1:0] w_keep;

    // Append the (possibly MSB-stripped) word behind the buffered bits and split off a frame.
    always_comb begin
        w_acc   = i_ce & i_in_vld;
        w_slip  = w_acc & (((r_state == S_IDLE) & i_bit_slp) | (r_state == S_PEND));
        w_word  = i_in_dat;
        if (w_slip) begin
            w_word[IW-1] = 1'b0;
        end
        w_n     = w_slip ? CW'(IW - 1) : CW'(IW);
        w_ext   = (BW'(r_buf) << w_n) | BW'(w_word);
        w_total = r_cnt + w_n;
        w_emit  = (w_total >= CW'(FW));
        w_rem   = w_emit ? (w_total - CW'(FW)) : w_total;
        w_frame = FW'(w_ext >> w_rem);
        w_keep  = RW'(w_ext & ~({BW{1'b1}} << w_rem));
    end

    // Buffer, frame output, strobes and slip state; everything holds while CE is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_out_dat <= '0;
            r_out_vld <= 1'b0;
            r_slp_ack <= 1'b0;
        end else if (i_ce) begin
            r_out_vld <= w_acc & w_emit;
            r_slp_ack <= w_slip;
            if (w_acc) begin
                r_buf <= w_keep;
                r_cnt <= w_rem;
                if (w_emit) begin
                    r_out_dat <= w_frame;
                end
            end
            case (r_state)
                S_IDLE: if (i_bit_slp && !w_acc) r_state <= S_PEND;
                S_PEND: if (w_acc) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_out_dat = r_out_dat;
    assign o_out_vld = r_out_vld;
    assign o_slp_ack = r_slp_ack;

endmodule

// File: tb/tb_sici_pcs_rx_gearbox.sv
// Bench for the Rx gearbox: a bit-queue model of the stream is advanced each
// cycle and the DUT outputs are compared against it after every clock edge.
module tb_sici_pcs_rx_gearbox;

    localparam int FW = 40;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic [IW-1:0] in_dat;
    logic          in_vld;
    logic          bit_slp;
    logic [FW-1:0] out_dat;
    logic          out_vld;
    logic          slp_ack;

    sici_pcs_rx_gearbox #(.FW(FW), .IW(IW)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_ce     (ce),
        .i_in_dat (in_dat),
        .i_in_vld (in_vld),
        .i_bit_slp(bit_slp),
        .o_out_dat(out_dat),
        .o_out_vld(out_vld),
        .o_slp_ack(slp_ack)
    );

    always #5 clk = ~clk;

    // behavioural model: stream of pending bits, oldest at the front
    bit            mq[$];
    bit            m_pend;
    logic [FW-1:0] m_dat;
    logic          m_vld;
    logic          m_ack;

    int n_chk  = 0;
    int n_pass = 0;
    int vld_cnt;
    int ack_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 1'b0;
        m_dat  = '0;
        m_vld  = 1'b0;
        m_ack  = 1'b0;
    endtask

    task automatic model_step();
        bit acc, slip;
        if (!ce) return;
        acc  = in_vld;
        slip = acc && (m_pend || bit_slp);
        if (!m_pend && bit_slp && !acc) m_pend = 1'b1;
        else if (m_pend && acc)         m_pend = 1'b0;
        if (acc) begin
            for (int i = IW - 1; i >= 0; i--) begin
                if (!(slip && i == IW - 1)) mq.push_back(in_dat[i]);
            end
        end
        m_vld = 1'b0;
        if (acc && mq.size() >= FW) begin
            for (int i = FW - 1; i >= 0; i--) m_dat[i] = mq.pop_front();
            m_vld = 1'b1;
        end
        m_ack = slip;
    endtask

    task automatic compare_outputs();
        chk("out_dat", 64'(out_dat), 64'(m_dat));
        chk("out_vld", 64'(out_vld), 64'(m_vld));
        chk("slp_ack", 64'(slp_ack), 64'(m_ack));
        if (out_vld) vld_cnt++;
        if (slp_ack) ack_cnt++;
    endtask

    // one clock: drive inputs, advance the model, sample 1 time unit after the edge
    task automatic cyc(input logic c, input logic v, input logic [IW-1:0] d, input logic s);
        ce = c; in_vld = v; in_dat = d; bit_slp = s;
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic word(input logic [IW-1:0] d, input logic s);
        cyc(1'b1, 1'b1, d, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
        chk("rst_pulse_dat", 64'(out_dat), 64'h0);
        chk("rst_pulse_vld", 64'(out_vld), 64'h0);
        vld_cnt = 0;
        ack_cnt = 0;
    endtask

    logic [IW-1:0] words5 [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [IW-1:0] words6 [6] = '{8'h81, 8'h02, 8'h03, 8'h04, 8'h05, 8'h80};

    initial begin
        rst_n = 1'b0; ce = 1'b0; in_vld = 1'b0; in_dat = '0; bit_slp = 1'b0;
        model_reset();
        vld_cnt = 0; ack_cnt = 0;

        // 1: reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            cyc(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            chk("t1_dat", 64'(out_dat), 64'h0);
            chk("t1_vld", 64'(out_vld), 64'h0);
            chk("t1_ack", 64'(slp_ack), 64'h0);
        end
        @(negedge clk);
        rst_pulse();

        // 2: five consecutive words
        for (int i = 0; i < 5; i++) begin
            word(words5[i], 1'b0);
            chk("t2_vld_timing", 64'(out_vld), (i == 4) ? 64'h1 : 64'h0);
        end
        chk("t2_dat", 64'(out_dat), 64'h0102030405);
        idle(3);
        chk("t2_vld_count", 64'(vld_cnt), 64'd1);

        // 3: gaps in In_Vld and CE low for three cycles mid-stream
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            word(words5[i], 1'b0);
            if (i == 4) chk("t3_vld_timing", 64'(out_vld), 64'h1);
            cyc(1'b1, 1'b0, 8'hFF, 1'b0);
            if (i == 2) begin
                for (int k = 0; k < 3; k++) begin
                    cyc(1'b0, 1'b1, 8'($urandom), 1'b1);
                    chk("t3_ce_hold_vld", 64'(out_vld), 64'h0);
                end
            end
        end
        chk("t3_dat", 64'(out_dat), 64'h0102030405);
        chk("t3_vld_count", 64'(vld_cnt), 64'd1);

        // 4: slip applied to the first word
        rst_pulse();
        for (int i = 0; i < 6; i++) begin
            word(words6[i], (i == 0));
            chk("t4_ack_timing", 64'(slp_ack), (i == 0) ? 64'h1 : 64'h0);
            chk("t4_vld_timing", 64'(out_vld), (i == 5) ? 64'h1 : 64'h0);
        end
        chk("t4_dat", 64'(out_dat), 64'h020406080B);
        word(8'h00, 1'b0);
        chk("t4_model_cnt", 64'(mq.size()), 64'd15);
        chk("t4_no_emit", 64'(out_vld), 64'h0);
        for (int i = 0; i < 4; i++) word(8'($urandom), 1'b0);
        chk("t4_vld_count", 64'(vld_cnt), 64'd2);

        // 5: slip held with no data, then words
        rst_pulse();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) word(words6[i], 1'b0);
        chk("t5_dat", 64'(out_dat), 64'h020406080B);
        chk("t5_ack_count", 64'(ack_cnt), 64'd1);
        chk("t5_vld_count", 64'(vld_cnt), 64'd1);

        // 6: reset after three words discards them
        rst_pulse();
        for (int i = 0; i < 3; i++) word(8'($urandom), 1'b0);
        rst_pulse();
        for (int i = 0; i < 5; i++) word(words5[i], 1'b0);
        chk("t6_dat", 64'(out_dat), 64'h0102030405);
        chk("t6_vld_count", 64'(vld_cnt), 64'd1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_pulse();
            end else begin
                cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
                    8'($urandom), ($urandom_range(0, 19) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
